instr_decode: RTL and testbench

Fetch-and-decode front end for the 16-bit CPU datapath. It holds the program counter and requests instruction words from instruction memory over a ready-based handshake. It decodes each word into register addresses, an ALU opcode and a write-enable, and produces the operand-B controls: `imm_sel`, which selects the immediate as operand B when high, and a 16-bit extended immediate. It presents each decoded instruction to the execute stage over a valid/ready handshake and accepts branch redirects from execute.

---
 rtl/instr_decode.sv | 146 ++++++++++++++
 tb/tb_instr_decode.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// Fetch-and-decode front end: PC, instruction fetch handshake, decode of the
// registered instruction word and valid/ready issue to execute with redirect.
module instr_decode #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic        imm_sel,
    output logic [15:0] immediate,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic [7:0]  alu_op,
    output logic        reg_we,
    output logic [15:0] pc_out,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    typedef enum logic [0:0] {
        ST_REQ   = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic [3:0] OP_REG  = 4'h0;
    localparam logic [3:0] OP_CMPI = 4'hB;
    localparam logic [3:0] OP_LOGI = 4'hE;
    localparam logic [3:0] OP_LUI  = 4'hF;
    localparam logic [3:0] EXT_CMP = 4'hB;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] inst_q, inst_d;

    logic [3:0]  op_s;
    logic [3:0]  opext_s;
    logic [7:0]  imm8_s;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] zext8(input logic [7:0] v);
        return {8'h00, v};
    endfunction

    // Next-state logic: redirect overrides any fetch or issue in progress.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        if (redirect) begin
            state_d = ST_REQ;
            pc_d    = redirect_pc;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (mem_ready) begin
                        inst_d   = mem_rdata;
                        pc_out_d = pc_q;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_REQ;
                    end
                end
                ST_ISSUE: begin
                    if (dec_ready) begin
                        pc_d    = pc_q + 16'h0001;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            inst_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = pc_q;
    assign dec_valid = (state_q == ST_ISSUE);
    assign pc_out    = pc_out_q;

    assign op_s    = inst_q[15:12];
    assign opext_s = inst_q[7:4];
    assign imm8_s  = inst_q[7:0];
    assign rdest   = inst_q[11:8];
    assign rsrc    = inst_q[3:0];

    // Operand-B selection and immediate extension by opcode class.
    always_comb begin
        imm_sel   = 1'b1;
        immediate = 16'h0000;
        alu_op    = {op_s, 4'h0};
        case (op_s)
            OP_REG: begin
                imm_sel   = 1'b0;
                immediate = 16'h0000;
                alu_op    = {op_s, opext_s};
            end
            OP_LOGI: begin
                immediate = zext8(imm8_s);
            end
            OP_LUI: begin
                immediate = {imm8_s, 8'h00};
            end
            default: begin
                immediate = sext8(imm8_s);
            end
        endcase
    end

    // Compares only set flags, so they never write the destination register.
    always_comb begin
        if ((op_s == OP_CMPI) || ((op_s == OP_REG) && (opext_s == EXT_CMP))) begin
            reg_we = 1'b0;
        end else begin
            reg_we = 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: scoreboard of fetched words against
// issued decodes plus directed checks of reset, stalls, redirect and wrap.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic        imm_sel;
    logic [15:0] immediate;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [7:0]  alu_op;
    logic        reg_we;
    logic [15:0] pc_out;
    logic        redirect;
    logic [15:0] redirect_pc;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    logic [63:0] sb_q [$];
    logic [15:0] prog [16];

    instr_decode #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .imm_sel(imm_sel), .immediate(immediate), .rdest(rdest), .rsrc(rsrc),
        .alu_op(alu_op), .reg_we(reg_we), .pc_out(pc_out),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    assign mem_rdata = prog[mem_addr[3:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference decode: {pc, imm_sel, immediate, rdest, rsrc, alu_op, reg_we}
    function automatic logic [63:0] model(input logic [15:0] pc, input logic [15:0] w);
        logic [3:0]  op;
        logic        sel;
        logic [15:0] imm;
        logic [7:0]  aop;
        logic        we;
        op = w[15:12];
        if (op == 4'h0) begin
            sel = 1'b0; imm = 16'h0000; aop = w[15:8] & 8'hF0 | {4'h0, w[7:4]};
        end else begin
            sel = 1'b1; aop = {op, 4'h0};
            if (op == 4'hE)      imm = {8'h00, w[7:0]};
            else if (op == 4'hF) imm = {w[7:0], 8'h00};
            else                 imm = {{8{w[7]}}, w[7:0]};
        end
        we = !(op == 4'hB || w[15:4] == 12'h00B || (op == 4'h0 && w[7:4] == 4'hB));
        return {14'h0, pc, sel, imm, w[11:8], w[3:0], aop, we};
    endfunction

    function automatic logic [63:0] observed();
        return {14'h0, pc_out, imm_sel, immediate, rdest, rsrc, alu_op, reg_we};
    endfunction

    // Scoreboard: push accepted fetches, pop and compare on each issue handshake.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            sb_q.delete();
        end else begin
            if (dec_valid && dec_ready) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) chk("sb_issue", observed(), sb_q.pop_front());
                hs_cnt++;
            end else if (dec_valid && redirect && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
            end
            if (mem_req && mem_ready && !redirect) sb_q.push_back(model(mem_addr, mem_rdata));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input string tag, input logic exp_sel, input logic [15:0] exp_imm,
                             input logic exp_we);
        step();
        @(negedge clk);
        chk({tag, "_valid"}, 64'(dec_valid), 64'd1);
        chk({tag, "_sel"}, 64'(imm_sel), 64'(exp_sel));
        chk({tag, "_imm"}, 64'(immediate), 64'(exp_imm));
        chk({tag, "_we"}, 64'(reg_we), 64'(exp_we));
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_before;
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
        prog[0] = 16'h0123; prog[1] = 16'h52F0; prog[2] = 16'hE2F0; prog[3] = 16'hF2AB;
        prog[4] = 16'hB305; prog[5] = 16'h1234; prog[6] = 16'h00B7; prog[15] = 16'h3480;
        reset = 1'b0; mem_ready = 1'b0; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        step(); step();
        @(negedge clk);
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_decode", observed(), {14'h0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, 8'h00, 1'b1});

        // First fetch with zero-wait memory
        step();
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("first_req", 64'(mem_req), 64'd1);
        chk("first_addr", 64'(mem_addr), 64'h0);
        step();
        @(negedge clk);
        chk("first_decode", observed(), {14'h0, 16'h0000, 1'b0, 16'h0000, 4'h1, 4'h3, 8'h02, 1'b1});
        chk("first_valid", 64'(dec_valid), 64'd1);

        // Back-pressure: decode outputs hold, no new request
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("bp_valid", 64'(dec_valid), 64'd1);
            chk("bp_req", 64'(mem_req), 64'd0);
            chk("bp_decode", observed(), {14'h0, 16'h0000, 1'b0, 16'h0000, 4'h1, 4'h3, 8'h02, 1'b1});
        end
        step();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_addr", 64'(mem_addr), 64'h1);
        chk("bp_next_req", 64'(mem_req), 64'd1);

        issue_one("sext", 1'b1, 16'hFFF0, 1'b1);
        issue_one("zext", 1'b1, 16'h00F0, 1'b1);
        issue_one("lui",  1'b1, 16'hAB00, 1'b1);
        issue_one("cmpi", 1'b1, 16'h0005, 1'b0);

        // Memory wait states
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_req", 64'(mem_req), 64'd1);
            chk("wait_addr", 64'(mem_addr), 64'h5);
            chk("wait_valid", 64'(dec_valid), 64'd0);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wait_ready_valid", 64'(dec_valid), 64'd0);
        step();
        @(negedge clk);
        chk("wait_done_valid", 64'(dec_valid), 64'd1);
        chk("wait_done_pc", 64'(pc_out), 64'h5);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;

        // Redirect coinciding with mem_ready discards the fetched word
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("rd_fetch_addr", 64'(mem_addr), 64'h40);
        chk("rd_fetch_valid", 64'(dec_valid), 64'd0);
        step();
        @(negedge clk);
        chk("rd_fetch_pc", 64'(pc_out), 64'h40);

        // Redirect coinciding with an issue handshake
        step();
        hs_before = hs_cnt;
        dec_ready = 1'b1; redirect = 1'b1;
        step();
        dec_ready = 1'b0; redirect = 1'b0;
        chk("rd_hs_counted", 64'(hs_cnt), 64'(hs_before + 1));
        @(negedge clk);
        chk("rd_hs_addr", 64'(mem_addr), 64'h40);
        chk("rd_hs_valid", 64'(dec_valid), 64'd0);

        // PC wrap
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr", 64'(mem_addr), 64'hFFFF);
        step();
        @(negedge clk);
        chk("wrap_pc", 64'(pc_out), 64'hFFFF);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        @(negedge clk);
        chk("wrap_next", 64'(mem_addr), 64'h0000);

        // Reset during a fetch with mem_ready pending
        redirect = 1'b1; redirect_pc = 16'h0007;
        step();
        redirect = 1'b0; reset = 1'b0; mem_ready = 1'b1;
        step();
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(dec_valid), 64'd0);
        chk("mrst_addr", 64'(mem_addr), 64'h0000);
        chk("mrst_pc", 64'(pc_out), 64'h0000);
        chk("mrst_req", 64'(mem_req), 64'd1);
        step();
        @(negedge clk);
        chk("mrst_hold", 64'(dec_valid), 64'd0);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
